// File: rtl/aurora_tx_seq_framer.sv
// rtl/aurora_tx_seq_framer.sv - store-and-forward Aurora TX framer with sequence trailer
module aurora_tx_seq_framer #(
    parameter int          MAX_WORDS = 64,
    parameter logic [31:0] SEQ_INIT  = 32'h0000_0000
) (
    input  logic        m_axis_aclk,
    input  logic        rst,
    input  logic        s_axis_tvalid,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic        m_axis_tvalid,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    input  logic        ctrl_seq_en,
    output logic [31:0] seq_num,
    output logic [15:0] drop_cnt
);
    localparam int AW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

    typedef enum logic [2:0] {FILL, DISCARD, SEND_DATA, SEND_SEQ, DONE} state_t;

    state_t        state, state_n;
    logic [31:0]   mem [MAX_WORDS];
    logic [AW-1:0] wr_ptr, rd_ptr, len_m1, rd_next;
    logic          seq_en_l, primed;
    logic          s_hs, m_hs, wr_full, rd_last;

    assign s_hs    = s_axis_tvalid & s_axis_tready;
    assign m_hs    = m_axis_tvalid & m_axis_tready;
    assign wr_full = (wr_ptr == AW'(MAX_WORDS - 1));
    assign rd_last = (rd_ptr == len_m1);
    assign rd_next = rd_ptr + AW'(1);

    always_ff @(posedge m_axis_aclk or posedge rst) begin
        if (rst) state <= FILL;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            FILL: begin
                if (s_hs) begin
                    if (s_axis_tlast) state_n = SEND_DATA;
                    else if (wr_full) state_n = DISCARD;
                end
            end
            DISCARD:   if (s_hs && s_axis_tlast) state_n = FILL;
            SEND_DATA: if (m_hs && rd_last) state_n = seq_en_l ? SEND_SEQ : DONE;
            SEND_SEQ:  if (m_hs) state_n = DONE;
            DONE:      state_n = FILL;
            default:   state_n = FILL;
        endcase
    end

    always_ff @(posedge m_axis_aclk) begin
        if (state == FILL && s_hs) mem[wr_ptr] <= s_axis_tdata;
    end

    // m_axis_tdata doubles as the RAM read register; after each handshake it is
    // loaded with the next word so a continuously-ready sink sees no bubbles.
    always_ff @(posedge m_axis_aclk or posedge rst) begin
        if (rst) begin
            s_axis_tready <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= 32'h0;
            m_axis_tlast  <= 1'b0;
            seq_num       <= SEQ_INIT;
            drop_cnt      <= 16'h0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            len_m1        <= '0;
            seq_en_l      <= 1'b0;
            primed        <= 1'b0;
        end else begin
            s_axis_tready <= (state_n == FILL) || (state_n == DISCARD);
            case (state)
                FILL: begin
                    if (s_hs) begin
                        if (s_axis_tlast) begin
                            len_m1   <= wr_ptr;
                            seq_en_l <= ctrl_seq_en;
                            rd_ptr   <= '0;
                            primed   <= 1'b0;
                        end else if (wr_full) begin
                            wr_ptr <= '0;
                        end else begin
                            wr_ptr <= wr_ptr + AW'(1);
                        end
                    end
                end
                DISCARD: begin
                    if (s_hs && s_axis_tlast) begin
                        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
                        wr_ptr <= '0;
                    end
                end
                SEND_DATA: begin
                    if (!m_axis_tvalid) begin
                        if (!primed) begin
                            m_axis_tdata <= mem[rd_ptr];
                            m_axis_tlast <= (len_m1 == '0) && !seq_en_l;
                            primed       <= 1'b1;
                        end else begin
                            m_axis_tvalid <= 1'b1;
                        end
                    end else if (m_axis_tready) begin
                        if (rd_last) begin
                            if (seq_en_l) begin
                                m_axis_tdata <= seq_num;
                                m_axis_tlast <= 1'b1;
                            end else begin
                                m_axis_tvalid <= 1'b0;
                                m_axis_tlast  <= 1'b0;
                            end
                        end else begin
                            rd_ptr       <= rd_next;
                            m_axis_tdata <= mem[rd_next];
                            m_axis_tlast <= (rd_next == len_m1) && !seq_en_l;
                        end
                    end
                end
                SEND_SEQ: begin
                    if (m_hs) begin
                        m_axis_tvalid <= 1'b0;
                        m_axis_tlast  <= 1'b0;
                    end
                end
                DONE: begin
                    if (seq_en_l) seq_num <= seq_num + 32'd1;
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aurora_tx_seq_framer.sv
// tb/tb_aurora_tx_seq_framer.sv - randomized self-checking bench for aurora_tx_seq_framer
module tb_aurora_tx_seq_framer;
    localparam int          MW = 64;
    localparam logic [31:0] SI = 32'hFFFF_FFFE;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_axis_tvalid = 1'b0;
    logic [31:0] s_axis_tdata = 32'h0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tready;
    logic        m_axis_tvalid;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tready = 1'b1;
    logic        ctrl_seq_en = 1'b1;
    logic [31:0] seq_num;
    logic [15:0] drop_cnt;

    aurora_tx_seq_framer #(.MAX_WORDS(MW), .SEQ_INIT(SI)) dut (
        .m_axis_aclk  (clk),
        .rst          (rst),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .ctrl_seq_en  (ctrl_seq_en),
        .seq_num      (seq_num),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0, checks = 0;
    int rdy_mode = 0, mon_errs = 0, busy_rdy = 0, timeouts = 0, tlast_cyc = 0;
    logic [31:0] pay[$];
    logic [31:0] exp_d[$];
    logic        exp_l[$];
    logic [31:0] cap_d[$];
    logic        cap_l[$];
    int          cap_c[$];
    logic [31:0] m_seq = SI;
    int          m_drop = 0;
    logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [31:0] pd = 32'h0;

    // passive output monitor: records beats, flags stall instability and mid-frame bubbles
    always @(negedge clk) begin
        if (!rst) begin
            if (pv && !pr && (!m_axis_tvalid || m_axis_tdata !== pd || m_axis_tlast !== pl))
                mon_errs++;
            if (pv && pr && !pl && !m_axis_tvalid) mon_errs++;
            if (m_axis_tvalid && s_axis_tready) busy_rdy++;
            if (m_axis_tvalid && m_axis_tready) begin
                cap_d.push_back(m_axis_tdata);
                cap_l.push_back(m_axis_tlast);
                cap_c.push_back(cyc);
            end
            pv = m_axis_tvalid; pr = m_axis_tready; pl = m_axis_tlast; pd = m_axis_tdata;
        end else begin
            pv = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = 1'($urandom_range(0, 1));
            default: m_axis_tready = 1'b0;
        endcase
    endtask

    task automatic clear_all();
        cap_d.delete(); cap_l.delete(); cap_c.delete();
        exp_d.delete(); exp_l.delete();
        mon_errs = 0; busy_rdy = 0; timeouts = 0;
    endtask

    task automatic fill_pay(input int n);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back($urandom());
    endtask

    // reference: payload words, then the trailer if enabled; oversized packets vanish
    task automatic model_pkt(input logic en);
        int n = pay.size();
        if (n > MW) begin
            m_drop++;
        end else begin
            for (int i = 0; i < n; i++) begin
                exp_d.push_back(pay[i]);
                exp_l.push_back((i == n - 1) && !en);
            end
            if (en) begin
                exp_d.push_back(m_seq);
                exp_l.push_back(1'b1);
                m_seq = m_seq + 32'd1;
            end
        end
    endtask

    task automatic send_pkt(input logic en);
        logic ok;
        int   guard;
        ctrl_seq_en = en;
        for (int i = 0; i < pay.size(); i++) begin
            if ($urandom_range(0, 3) == 0) begin
                s_axis_tvalid = 1'b0;
                tick();
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = pay[i];
            s_axis_tlast  = (i == pay.size() - 1);
            guard = 0;
            do begin
                @(negedge clk);
                ok = s_axis_tready;
                tick();
                guard++;
            end while (!ok && guard < 500);
            if (!ok) timeouts++;
        end
        tlast_cyc     = cyc;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_caps(input int n, input int budget);
        int k = 0;
        while (cap_d.size() < n && k < budget) begin
            tick();
            k++;
        end
    endtask

    task automatic test_reset();
        rdy_mode = 0;
        tick(); tick();
        @(negedge clk);
        checks += 6;
        if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %b expected 0", s_axis_tready); end
        if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %b expected 0", m_axis_tvalid); end
        if (m_axis_tdata !== 32'h0) begin errors++; $display("FAIL rst_m_data: got %h expected 0", m_axis_tdata); end
        if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL rst_m_last: got %b expected 0", m_axis_tlast); end
        if (seq_num !== SI) begin errors++; $display("FAIL rst_seq: got %h expected %h", seq_num, SI); end
        if (drop_cnt !== 16'h0) begin errors++; $display("FAIL rst_drop: got %h expected 0", drop_cnt); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL rel_ready_early: got %b expected 0", s_axis_tready); end
        tick();
        @(negedge clk);
        checks++;
        if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL rel_ready_rise: got %b expected 1", s_axis_tready); end
        tick();
    endtask

    task automatic test_basic();
        clear_all();
        fill_pay(3);
        model_pkt(1'b1);
        send_pkt(1'b1);
        wait_caps(exp_d.size(), 100);
        tick(); tick();
        checks++;
        if (cap_d.size() !== exp_d.size()) begin errors++; $display("FAIL basic_count: got %0d expected %0d", cap_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < cap_d.size(); i++) begin
            checks++;
            if (cap_d[i] !== exp_d[i] || cap_l[i] !== exp_l[i]) begin
                errors++; $display("FAIL basic_word%0d: got %h/%b expected %h/%b", i, cap_d[i], cap_l[i], exp_d[i], exp_l[i]);
            end
        end
        if (cap_c.size() > 0) begin
            checks++;
            if (cap_c[0] !== tlast_cyc + 2) begin errors++; $display("FAIL basic_latency: got cycle %0d expected %0d", cap_c[0], tlast_cyc + 2); end
        end
        checks += 3;
        if (seq_num !== m_seq) begin errors++; $display("FAIL basic_seq: got %h expected %h", seq_num, m_seq); end
        if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL basic_ready_back: got %b expected 1", s_axis_tready); end
        if (mon_errs + timeouts !== 0) begin errors++; $display("FAIL basic_protocol: got %0d violations expected 0", mon_errs + timeouts); end
    endtask

    task automatic test_back_to_back();
        clear_all();
        fill_pay(1); model_pkt(1'b1); send_pkt(1'b1);
        fill_pay(1); model_pkt(1'b1); send_pkt(1'b1);
        wait_caps(exp_d.size(), 100);
        tick(); tick();
        checks++;
        if (cap_d.size() !== exp_d.size()) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", cap_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < cap_d.size(); i++) begin
            checks++;
            if (cap_d[i] !== exp_d[i] || cap_l[i] !== exp_l[i]) begin
                errors++; $display("FAIL b2b_word%0d: got %h/%b expected %h/%b", i, cap_d[i], cap_l[i], exp_d[i], exp_l[i]);
            end
        end
        checks += 2;
        if (busy_rdy !== 0) begin errors++; $display("FAIL b2b_ready_in_send: got %0d cycles expected 0", busy_rdy); end
        if (seq_num !== m_seq) begin errors++; $display("FAIL b2b_seq: got %h expected %h", seq_num, m_seq); end
    endtask

    task automatic test_random_stall();
        clear_all();
        fill_pay(MW);
        model_pkt(1'b1);
        send_pkt(1'b1);
        rdy_mode = 1;
        wait_caps(exp_d.size(), 2000);
        rdy_mode = 0;
        tick(); tick(); tick();
        checks++;
        if (cap_d.size() !== exp_d.size()) begin errors++; $display("FAIL stall_count: got %0d expected %0d", cap_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < cap_d.size(); i++) begin
            checks++;
            if (cap_d[i] !== exp_d[i] || cap_l[i] !== exp_l[i]) begin
                errors++; $display("FAIL stall_word%0d: got %h/%b expected %h/%b", i, cap_d[i], cap_l[i], exp_d[i], exp_l[i]);
            end
        end
        checks++;
        if (mon_errs + timeouts !== 0) begin errors++; $display("FAIL stall_protocol: got %0d violations expected 0", mon_errs + timeouts); end
    endtask

    task automatic test_oversize_drop();
        clear_all();
        fill_pay(MW + 6); model_pkt(1'b1); send_pkt(1'b1);
        fill_pay(2);      model_pkt(1'b1); send_pkt(1'b1);
        wait_caps(exp_d.size(), 200);
        tick(); tick(); tick();
        checks++;
        if (cap_d.size() !== exp_d.size()) begin errors++; $display("FAIL drop_count_words: got %0d expected %0d", cap_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < cap_d.size(); i++) begin
            checks++;
            if (cap_d[i] !== exp_d[i] || cap_l[i] !== exp_l[i]) begin
                errors++; $display("FAIL drop_word%0d: got %h/%b expected %h/%b", i, cap_d[i], cap_l[i], exp_d[i], exp_l[i]);
            end
        end
        checks += 2;
        if (drop_cnt !== 16'(m_drop)) begin errors++; $display("FAIL drop_cnt: got %0d expected %0d", drop_cnt, m_drop); end
        if (seq_num !== m_seq) begin errors++; $display("FAIL drop_seq: got %h expected %h", seq_num, m_seq); end
    endtask

    task automatic test_seq_disabled();
        int k = 0;
        clear_all();
        fill_pay(4);
        model_pkt(1'b0);
        send_pkt(1'b0);
        while (cap_d.size() < exp_d.size() && k < 100) begin
            ctrl_seq_en = ~ctrl_seq_en;
            tick();
            k++;
        end
        tick(); tick(); tick(); tick();
        ctrl_seq_en = 1'b1;
        checks++;
        if (cap_d.size() !== exp_d.size()) begin errors++; $display("FAIL noseq_count: got %0d expected %0d", cap_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < cap_d.size(); i++) begin
            checks++;
            if (cap_d[i] !== exp_d[i] || cap_l[i] !== exp_l[i]) begin
                errors++; $display("FAIL noseq_word%0d: got %h/%b expected %h/%b", i, cap_d[i], cap_l[i], exp_d[i], exp_l[i]);
            end
        end
        checks++;
        if (seq_num !== m_seq) begin errors++; $display("FAIL noseq_seq: got %h expected %h", seq_num, m_seq); end
    endtask

    task automatic test_reset_mid_send();
        int k = 0;
        clear_all();
        rdy_mode = 2;
        fill_pay(5);
        send_pkt(1'b1);
        while (!m_axis_tvalid && k < 50) begin
            tick();
            k++;
        end
        checks++;
        if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL midrst_presend: got valid %b expected 1", m_axis_tvalid); end
        #1;
        rst = 1'b1;
        #1;
        checks += 6;
        if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL midrst_s_ready: got %b expected 0", s_axis_tready); end
        if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL midrst_m_valid: got %b expected 0", m_axis_tvalid); end
        if (m_axis_tdata !== 32'h0) begin errors++; $display("FAIL midrst_m_data: got %h expected 0", m_axis_tdata); end
        if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL midrst_m_last: got %b expected 0", m_axis_tlast); end
        if (seq_num !== SI) begin errors++; $display("FAIL midrst_seq: got %h expected %h", seq_num, SI); end
        if (drop_cnt !== 16'h0) begin errors++; $display("FAIL midrst_drop: got %h expected 0", drop_cnt); end
        rdy_mode = 0;
        tick(); tick();
        rst = 1'b0;
        m_seq = SI;
        m_drop = 0;
        clear_all();
        for (int p = 1; p <= 3; p++) begin
            fill_pay(p);
            model_pkt(1'b1);
            send_pkt(1'b1);
        end
        wait_caps(exp_d.size(), 300);
        tick(); tick();
        checks++;
        if (cap_d.size() !== exp_d.size()) begin errors++; $display("FAIL wrap_count: got %0d expected %0d", cap_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < cap_d.size(); i++) begin
            checks++;
            if (cap_d[i] !== exp_d[i] || cap_l[i] !== exp_l[i]) begin
                errors++; $display("FAIL wrap_word%0d: got %h/%b expected %h/%b", i, cap_d[i], cap_l[i], exp_d[i], exp_l[i]);
            end
        end
        if (cap_d.size() > 0) begin
            checks++;
            if (cap_d[cap_d.size() - 1] !== 32'h0) begin errors++; $display("FAIL wrap_trailer: got %h expected 00000000", cap_d[cap_d.size() - 1]); end
        end
        checks += 2;
        if (seq_num !== 32'h1) begin errors++; $display("FAIL wrap_seq: got %h expected 00000001", seq_num); end
        if (mon_errs + timeouts !== 0) begin errors++; $display("FAIL wrap_protocol: got %0d violations expected 0", mon_errs + timeouts); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_random_stall();
        test_oversize_drop();
        test_seq_disabled();
        test_reset_mid_send();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
